// File: rtl/hps_spi_pkg.sv
// Shared types and sizing helpers for the HPS-side SPI master.
package hps_spi_pkg;

  typedef enum logic [1:0] {IDLE, SETUP, SHIFT, GAP} state_e;

  localparam int WORD_BITS_DEFAULT = 16;
  localparam int BIT_CNT_W         = $clog2(WORD_BITS_DEFAULT + 1);

  function automatic int bit_cnt_width(input int word_bits);
    return $clog2(word_bits + 1);
  endfunction

endpackage

// File: rtl/hps_spi_tick.sv
// Free-running half-period counter: tick is high in the last cycle of every
// CLK_DIV-cycle window; clear restarts the window so the next cycle is count 0.
module hps_spi_tick #(
  parameter int CLK_DIV = 4
) (
  input  logic clk_sys,
  input  logic reset,
  input  logic clear,
  output logic tick
);

  localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(CLK_DIV - 1);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q + CW'(1);
    if (clear || (cnt_q == LAST)) begin
      cnt_d = '0;
    end
  end

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign tick = (cnt_q == LAST);

endmodule

// File: rtl/hps_spi_master.sv
// SPI mode-0 master, MSB first, one full-duplex WORD_BITS transfer per accepted start.
// Define HPS_SPI_BURST_EN to add the burst input that keeps cs low across back-to-back words.
module hps_spi_master
  import hps_spi_pkg::*;
#(
  parameter int CLK_DIV   = 4,
  parameter int WORD_BITS = 16,
  parameter int CS_GAP    = 2
) (
  input  logic                 clk_sys,
  input  logic                 reset,
  input  logic [WORD_BITS-1:0] tx_word,
  input  logic                 start,
`ifdef HPS_SPI_BURST_EN
  input  logic                 burst,
`endif
  output logic                 ready,
  output logic [WORD_BITS-1:0] rx_word,
  output logic                 rx_done,
  output logic                 spi_clk,
  output logic                 spi_mosi,
  input  logic                 spi_miso,
  output logic                 spi_cs
);

  localparam int BCW = bit_cnt_width(WORD_BITS);
  localparam int GW  = $clog2(CS_GAP + 1);

  state_e               state_q, state_d;
  logic [WORD_BITS-1:0] tx_sr_q, tx_sr_d;
  logic [WORD_BITS-2:0] rx_sr_q, rx_sr_d;
  logic [BCW-1:0]       bit_cnt_q, bit_cnt_d;
  logic [GW-1:0]        gap_cnt_q, gap_cnt_d;
  logic                 sck_q, sck_d;
  logic                 cs_q, cs_d;
  logic                 ready_q, ready_d;
  logic                 rx_done_q, rx_done_d;
  logic [WORD_BITS-1:0] rx_word_q, rx_word_d;
  logic                 burst_q, burst_d;
  logic                 burst_in;
  logic                 accept;
  logic                 tick;

`ifdef HPS_SPI_BURST_EN
  assign burst_in = burst;
`else
  assign burst_in = 1'b0;
`endif

  assign accept = start && ready_q;

  hps_spi_tick #(.CLK_DIV(CLK_DIV)) u_tick (
    .clk_sys (clk_sys),
    .reset   (reset),
    .clear   (accept),
    .tick    (tick)
  );

  always_comb begin
    state_d   = state_q;
    tx_sr_d   = tx_sr_q;
    rx_sr_d   = rx_sr_q;
    bit_cnt_d = bit_cnt_q;
    gap_cnt_d = gap_cnt_q;
    sck_d     = sck_q;
    cs_d      = cs_q;
    ready_d   = ready_q;
    rx_done_d = 1'b0;
    rx_word_d = rx_word_q;
    burst_d   = burst_q;
    unique case (state_q)
      IDLE: begin
        if (accept) begin
          state_d   = SETUP;
          tx_sr_d   = tx_word;
          cs_d      = 1'b0;
          sck_d     = 1'b0;
          ready_d   = 1'b0;
          bit_cnt_d = '0;
          burst_d   = burst_in;
        end else if (!cs_q) begin
          // Burst ended without a follow-on word: the cs rise cycle is the first gap cycle.
          state_d   = GAP;
          cs_d      = 1'b1;
          ready_d   = 1'b0;
          gap_cnt_d = GW'(1);
        end
      end
      SETUP: begin
        if (tick) begin
          sck_d   = 1'b1;
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        if (tick) begin
          if (!sck_q) begin
            sck_d = 1'b1;
          end else begin
            sck_d     = 1'b0;
            tx_sr_d   = {tx_sr_q[WORD_BITS-2:0], 1'b0};
            rx_sr_d   = {rx_sr_q[WORD_BITS-3:0], spi_miso};
            bit_cnt_d = bit_cnt_q + BCW'(1);
            if (bit_cnt_q == BCW'(WORD_BITS - 1)) begin
              rx_word_d = {rx_sr_q, spi_miso};
              rx_done_d = 1'b1;
              if (burst_q) begin
                state_d = IDLE;
                ready_d = 1'b1;
              end else begin
                state_d   = GAP;
                cs_d      = 1'b1;
                gap_cnt_d = '0;
              end
            end
          end
        end
      end
      GAP: begin
        if (gap_cnt_q == GW'(CS_GAP)) begin
          state_d = IDLE;
          ready_d = 1'b1;
        end else begin
          gap_cnt_d = gap_cnt_q + GW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      state_q   <= IDLE;
      tx_sr_q   <= '0;
      rx_sr_q   <= '0;
      bit_cnt_q <= '0;
      gap_cnt_q <= '0;
      sck_q     <= 1'b0;
      cs_q      <= 1'b1;
      ready_q   <= 1'b1;
      rx_done_q <= 1'b0;
      rx_word_q <= '0;
      burst_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      tx_sr_q   <= tx_sr_d;
      rx_sr_q   <= rx_sr_d;
      bit_cnt_q <= bit_cnt_d;
      gap_cnt_q <= gap_cnt_d;
      sck_q     <= sck_d;
      cs_q      <= cs_d;
      ready_q   <= ready_d;
      rx_done_q <= rx_done_d;
      rx_word_q <= rx_word_d;
      burst_q   <= burst_d;
    end
  end

  // mosi is the shift-register MSB, so it reads 0 once all bits have gone out.
  assign spi_mosi = tx_sr_q[WORD_BITS-1];
  assign spi_clk  = sck_q;
  assign spi_cs   = cs_q;
  assign ready    = ready_q;
  assign rx_done  = rx_done_q;
  assign rx_word  = rx_word_q;

endmodule

// File: tb/tb_hps_spi_master.sv
// Directed bench for hps_spi_master with a mode-0 slave model; burst test needs HPS_SPI_BURST_EN.
module tb_hps_spi_master;

  localparam int W = 16;

  logic          clk_sys = 1'b0;
  logic          reset   = 1'b1;
  logic          start   = 1'b0;
  logic [W-1:0]  tx_word = '0;
  logic          spi_miso = 1'b0;
  logic          ready, rx_done, spi_clk, spi_mosi, spi_cs;
  logic [W-1:0]  rx_word;
`ifdef HPS_SPI_BURST_EN
  logic          burst = 1'b0;
`endif

  hps_spi_master dut (
    .clk_sys  (clk_sys),
    .reset    (reset),
    .tx_word  (tx_word),
    .start    (start),
`ifdef HPS_SPI_BURST_EN
    .burst    (burst),
`endif
    .ready    (ready),
    .rx_word  (rx_word),
    .rx_done  (rx_done),
    .spi_clk  (spi_clk),
    .spi_mosi (spi_mosi),
    .spi_miso (spi_miso),
    .spi_cs   (spi_cs)
  );

  always #5 clk_sys = ~clk_sys;

  int cyc = 0;
  always @(posedge clk_sys) cyc <= cyc + 1;

  int total = 0;
  int bad   = 0;

  logic [W-1:0] resp = 16'h3C5A;
  bit           loopback = 1'b0;
  int           idx = 0;
  logic [W-1:0] mosi_cap = '0, done_mosi = '0, done_word = '0;
  int           done_cnt = 0, done_cyc = 0, cs_rise_cnt = 0, cs_hi_run = 0, cs_min_run = 1000;
  logic         prev_cs = 1'b1, prev_sck = 1'b0;

  // Slave model and monitor, evaluated mid-cycle.
  initial begin
    forever begin
      @(negedge clk_sys);
      if (spi_clk && !prev_sck) mosi_cap = {mosi_cap[W-2:0], spi_mosi};
      if (!spi_clk && prev_sck) begin
        idx++;
        if (idx >= W) idx = 0;
      end
      if (!spi_cs && prev_cs) begin
        idx = 0;
        mosi_cap = '0;
        if (cs_hi_run > 0 && cs_hi_run < cs_min_run) cs_min_run = cs_hi_run;
      end
      if (spi_cs && !prev_cs) begin
        idx = 0;
        cs_rise_cnt++;
      end
      cs_hi_run = spi_cs ? cs_hi_run + 1 : 0;
      if (rx_done) begin
        done_cyc  = cyc;
        done_word = rx_word;
        done_mosi = mosi_cap;
        done_cnt++;
      end
      spi_miso = loopback ? spi_mosi : resp[W-1-idx];
      prev_cs  = spi_cs;
      prev_sck = spi_clk;
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, required finish before 2ms");
    $fatal(1, "watchdog");
  end

  task automatic send(input logic [W-1:0] tx, output int acc);
    int n = 0;
    while (!ready && n < 2000) begin
      @(negedge clk_sys);
      n++;
    end
    total++;
    if (ready !== 1'b1) begin
      bad++;
      $display("FAIL send_ready_timeout: ready=%b required=1", ready);
    end
    tx_word = tx;
    start   = 1'b1;
    acc     = cyc;
    @(negedge clk_sys);
    start   = 1'b0;
    tx_word = ~tx;
  endtask

  task automatic wait_done(input int target);
    int n = 0;
    while (done_cnt < target && n < 3000) begin
      @(negedge clk_sys);
      n++;
    end
    total++;
    if (done_cnt < target) begin
      bad++;
      $display("FAIL rx_done_timeout: count=%0d required=%0d", done_cnt, target);
    end
  endtask

  task automatic test_reset;
    reset = 1'b1;
    repeat (3) @(negedge clk_sys);
    reset = 1'b0;
    @(negedge clk_sys);
    total += 6;
    if (ready !== 1'b1)     begin bad++; $display("FAIL reset_ready: got=%b want=1", ready); end
    if (rx_done !== 1'b0)   begin bad++; $display("FAIL reset_rx_done: got=%b want=0", rx_done); end
    if (rx_word !== 16'h0)  begin bad++; $display("FAIL reset_rx_word: got=%h want=0000", rx_word); end
    if (spi_clk !== 1'b0)   begin bad++; $display("FAIL reset_sck: got=%b want=0", spi_clk); end
    if (spi_mosi !== 1'b0)  begin bad++; $display("FAIL reset_mosi: got=%b want=0", spi_mosi); end
    if (spi_cs !== 1'b1)    begin bad++; $display("FAIL reset_cs: got=%b want=1", spi_cs); end
    $display("test_reset: outputs checked after reset");
  endtask

  task automatic test_basic;
    int acc;
    int base = done_cnt;
    loopback = 1'b0;
    resp = 16'h3C5A;
    send(16'hA5C3, acc);
    total += 4;
    if (ready !== 1'b0)    begin bad++; $display("FAIL basic_c1_ready: got=%b want=0", ready); end
    if (spi_cs !== 1'b0)   begin bad++; $display("FAIL basic_c1_cs: got=%b want=0", spi_cs); end
    if (spi_mosi !== 1'b1) begin bad++; $display("FAIL basic_c1_mosi: got=%b want=1", spi_mosi); end
    if (spi_clk !== 1'b0)  begin bad++; $display("FAIL basic_c1_sck: got=%b want=0", spi_clk); end
    wait_done(base + 1);
    total += 3;
    if (done_cyc - acc != 129) begin bad++; $display("FAIL basic_latency: got=%0d want=129", done_cyc - acc); end
    if (done_word !== 16'h3C5A) begin bad++; $display("FAIL basic_rx_word: got=%h want=3c5a", done_word); end
    if (done_mosi !== 16'hA5C3) begin bad++; $display("FAIL basic_mosi: got=%h want=a5c3", done_mosi); end
    $display("test_basic: tx=a5c3 rx=%h latency=%0d", done_word, done_cyc - acc);
  endtask

  task automatic test_continuous;
    int a[3];
    int n = 0;
    int k = 0;
    int base = done_cnt;
    cs_min_run = 1000;
    tx_word = 16'h1234;
    start = 1'b1;
    while (n < 3 && k < 2000) begin
      if (ready) begin
        a[n] = cyc;
        n++;
      end
      @(negedge clk_sys);
      k++;
    end
    start = 1'b0;
    wait_done(base + 3);
    repeat (200) @(negedge clk_sys);
    total += 5;
    if (n != 3) begin bad++; $display("FAIL cont_accepts: got=%0d want=3", n); end
    if (a[1] - a[0] != 132) begin bad++; $display("FAIL cont_spacing1: got=%0d want=132", a[1] - a[0]); end
    if (a[2] - a[1] != 132) begin bad++; $display("FAIL cont_spacing2: got=%0d want=132", a[2] - a[1]); end
    if (done_cnt - base != 3) begin bad++; $display("FAIL cont_done_count: got=%0d want=3", done_cnt - base); end
    if (cs_min_run < 2) begin bad++; $display("FAIL cont_cs_gap: got=%0d want>=2", cs_min_run); end
    $display("test_continuous: spacing=%0d,%0d min_cs_high=%0d", a[1] - a[0], a[2] - a[1], cs_min_run);
  endtask

  task automatic test_reset_mid;
    int acc;
    int n = 0;
    int base = done_cnt;
    resp = 16'h3C5A;
    send(16'h5A5A, acc);
    while (idx < 8 && n < 1000) begin
      @(negedge clk_sys);
      n++;
    end
    reset = 1'b1;
    @(negedge clk_sys);
    total += 4;
    if (spi_cs !== 1'b1)  begin bad++; $display("FAIL mid_reset_cs: got=%b want=1", spi_cs); end
    if (spi_clk !== 1'b0) begin bad++; $display("FAIL mid_reset_sck: got=%b want=0", spi_clk); end
    if (ready !== 1'b1)   begin bad++; $display("FAIL mid_reset_ready: got=%b want=1", ready); end
    if (rx_done !== 1'b0) begin bad++; $display("FAIL mid_reset_rx_done: got=%b want=0", rx_done); end
    reset = 1'b0;
    repeat (200) @(negedge clk_sys);
    total++;
    if (done_cnt != base) begin bad++; $display("FAIL mid_reset_no_done: got=%0d want=%0d", done_cnt, base); end
    resp = 16'hC0DE;
    send(16'h1357, acc);
    wait_done(base + 1);
    total += 2;
    if (done_word !== 16'hC0DE) begin bad++; $display("FAIL mid_reset_next_rx: got=%h want=c0de", done_word); end
    if (done_mosi !== 16'h1357) begin bad++; $display("FAIL mid_reset_next_mosi: got=%h want=1357", done_mosi); end
    $display("test_reset_mid: next transfer rx=%h", done_word);
  endtask

  task automatic test_busy;
    int acc;
    int base = done_cnt;
    resp = 16'h6B2D;
    send(16'h0F0F, acc);
    repeat (10) @(negedge clk_sys);
    tx_word = 16'hFFFF;
    start = 1'b1;
    @(negedge clk_sys);
    start = 1'b0;
    total += 2;
    if (ready !== 1'b0)  begin bad++; $display("FAIL busy_ready: got=%b want=0", ready); end
    if (spi_cs !== 1'b0) begin bad++; $display("FAIL busy_cs: got=%b want=0", spi_cs); end
    wait_done(base + 1);
    repeat (20) @(negedge clk_sys);
    total += 5;
    if (done_mosi !== 16'h0F0F) begin bad++; $display("FAIL busy_mosi: got=%h want=0f0f", done_mosi); end
    if (done_word !== 16'h6B2D) begin bad++; $display("FAIL busy_rx: got=%h want=6b2d", done_word); end
    if (done_cnt != base + 1)   begin bad++; $display("FAIL busy_done_count: got=%0d want=%0d", done_cnt, base + 1); end
    if (spi_cs !== 1'b1)        begin bad++; $display("FAIL busy_idle_cs: got=%b want=1", spi_cs); end
    if (ready !== 1'b1)         begin bad++; $display("FAIL busy_idle_ready: got=%b want=1", ready); end
    tx_word = 16'hAAAA;
    start = 1'b1;
    reset = 1'b1;
    @(negedge clk_sys);
    start = 1'b0;
    reset = 1'b0;
    total += 2;
    if (ready !== 1'b1)  begin bad++; $display("FAIL start_reset_ready: got=%b want=1", ready); end
    if (spi_cs !== 1'b1) begin bad++; $display("FAIL start_reset_cs: got=%b want=1", spi_cs); end
    repeat (10) @(negedge clk_sys);
    total++;
    if (spi_cs !== 1'b1) begin bad++; $display("FAIL start_reset_later_cs: got=%b want=1", spi_cs); end
    $display("test_busy: busy start and start+reset ignored");
  endtask

  task automatic test_loopback;
    logic [W-1:0] w[3];
    int acc;
    w[0] = 16'h0000;
    w[1] = 16'hFFFF;
    w[2] = 16'h8001;
    loopback = 1'b1;
    for (int i = 0; i < 3; i++) begin
      int base = done_cnt;
      send(w[i], acc);
      wait_done(base + 1);
      total++;
      if (done_word !== w[i]) begin bad++; $display("FAIL loopback_%0d: got=%h want=%h", i, done_word, w[i]); end
      $display("test_loopback: tx=%h rx=%h", w[i], done_word);
    end
    loopback = 1'b0;
  endtask

`ifdef HPS_SPI_BURST_EN
  task automatic test_burst;
    logic [W-1:0] w[3];
    int a[3];
    int n = 0;
    int k = 0;
    int base = done_cnt;
    int r0 = cs_rise_cnt;
    w[0] = 16'h1111;
    w[1] = 16'h2468;
    w[2] = 16'hBEEF;
    loopback = 1'b1;
    burst = 1'b1;
    tx_word = w[0];
    start = 1'b1;
    while (n < 3 && k < 3000) begin
      if (ready) begin
        a[n] = cyc;
        n++;
        @(negedge clk_sys);
        k++;
        if (n < 3) tx_word = w[n];
      end else begin
        @(negedge clk_sys);
        k++;
      end
    end
    start = 1'b0;
    burst = 1'b0;
    wait_done(base + 3);
    repeat (20) @(negedge clk_sys);
    total += 6;
    if (n != 3) begin bad++; $display("FAIL burst_accepts: got=%0d want=3", n); end
    if (a[1] - a[0] != 129) begin bad++; $display("FAIL burst_spacing1: got=%0d want=129", a[1] - a[0]); end
    if (a[2] - a[1] != 129) begin bad++; $display("FAIL burst_spacing2: got=%0d want=129", a[2] - a[1]); end
    if (cs_rise_cnt - r0 != 1) begin bad++; $display("FAIL burst_cs_rises: got=%0d want=1", cs_rise_cnt - r0); end
    if (done_word !== w[2]) begin bad++; $display("FAIL burst_last_rx: got=%h want=%h", done_word, w[2]); end
    if (ready !== 1'b1) begin bad++; $display("FAIL burst_end_ready: got=%b want=1", ready); end
    loopback = 1'b0;
    $display("test_burst: spacing=%0d,%0d cs_rises=%0d", a[1] - a[0], a[2] - a[1], cs_rise_cnt - r0);
  endtask
`endif

  initial begin
    @(negedge clk_sys);
    test_reset();
    test_basic();
    test_continuous();
    test_reset_mid();
    test_busy();
    test_loopback();
`ifdef HPS_SPI_BURST_EN
    test_burst();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
